parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 112 +++++++++++
 tb/tb_parking_gate_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: debounced entry/exit barriers with coin payment and occupancy tracking
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int DB_CYCLES   = 4,
  parameter int FEE         = 3,
  parameter int OPEN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_btn,
  input  logic             entry_pass,
  input  logic             exit_req,
  input  logic [1:0]       coin,
  input  logic             exit_pass,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             full,
  output logic [CNT_W-1:0] occupancy,
  output logic             paying,
  output logic [3:0]       change,
  output logic             change_vld,
  output logic             err
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(OPEN_CYCLES + 1);
  typedef enum logic {E_IDLE, E_OPEN} e_state_t;
  typedef enum logic [1:0] {X_IDLE, X_PAY, X_OPEN} x_state_t;
  e_state_t e_q, e_d;
  x_state_t x_q, x_d;
  logic [TW-1:0] et_q, et_d, xt_q, xt_d;
  logic [4:0] credit_q, credit_d, sum;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic err_q, err_d, ep_q, xp_q, ent_edge, ext_edge, inc, dec;
  logic [1:0] btn, s1_q, s2_q, pulse;
  assign btn = {exit_req, entry_btn};
  // counter saturates at DB_CYCLES so a held button pulses only once
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DW-1:0] cnt_q;
    always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= !s2_q[i] ? '0 : (cnt_q == DW'(DB_CYCLES)) ? cnt_q : cnt_q + DW'(1);
    assign pulse[i] = s2_q[i] && cnt_q == DW'(DB_CYCLES - 1);
  end
  assign ent_edge = entry_pass && !ep_q;
  assign ext_edge = exit_pass && !xp_q;
  assign full = occ_q == CNT_W'(CAPACITY);
  assign occupancy = occ_q;
  assign err = err_q;
  assign entry_gate = e_q == E_OPEN;
  assign exit_gate = x_q == X_OPEN;
  assign paying = x_q == X_PAY;
  assign sum = credit_q + {3'b0, coin};
  always_comb begin
    e_d = e_q;
    et_d = '0;
    x_d = x_q;
    xt_d = '0;
    credit_d = credit_q;
    change = '0;
    change_vld = 1'b0;
    if (e_q == E_IDLE) e_d = (pulse[0] && !full) ? E_OPEN : E_IDLE;
    else if (ent_edge || et_q == TW'(OPEN_CYCLES - 1)) e_d = E_IDLE;
    else et_d = et_q + TW'(1);
    case (x_q)
      X_IDLE: if (pulse[1] && occ_q != '0) begin
        x_d = X_PAY;
        credit_d = '0;
      end
      X_PAY: if (sum >= 5'(FEE)) begin
        x_d = X_OPEN;
        change_vld = 1'b1;
        change = 4'(sum - 5'(FEE));
        credit_d = '0;
      end else credit_d = sum;
      X_OPEN: if (ext_edge || xt_q == TW'(OPEN_CYCLES - 1)) x_d = X_IDLE;
        else xt_d = xt_q + TW'(1);
      default: x_d = X_IDLE;
    endcase
    inc = e_q == E_OPEN && ent_edge && !full;
    dec = x_q == X_OPEN && ext_edge && occ_q != '0;
    occ_d = (inc == dec) ? occ_q : inc ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
    err_d = err_q || (ext_edge && occ_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= E_IDLE;
      x_q <= X_IDLE;
      et_q <= '0;
      xt_q <= '0;
      credit_q <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
      ep_q <= 1'b0;
      xp_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      e_q <= e_d;
      x_q <= x_d;
      et_q <= et_d;
      xt_q <= xt_d;
      credit_q <= credit_d;
      occ_q <= occ_d;
      err_q <= err_d;
      ep_q <= entry_pass;
      xp_q <= exit_pass;
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scenarios plus random traffic checked against a behavioural model
module tb_parking_gate_ctrl;
  localparam int CAP = 8, DB = 4, FEE = 3, OC = 16;
  logic clk = 0, rst = 1, eb = 0, ep = 0, xr = 0, xp = 0;
  logic [1:0] cn = 0;
  logic entry_gate, exit_gate, full, paying, change_vld, err;
  logic [3:0] occupancy, change;
  int errors = 0, checks = 0;
  int m_occ, m_credit, m_eage, m_xage, m_xst, m_erun, m_xrun;
  bit m_eopen, m_err, m_ep, m_xp;
  bit [1:0] m_eh, m_xh;

  parking_gate_ctrl dut (
    .clk(clk), .rst(rst), .entry_btn(eb), .entry_pass(ep), .exit_req(xr), .coin(cn),
    .exit_pass(xp), .entry_gate(entry_gate), .exit_gate(exit_gate), .full(full),
    .occupancy(occupancy), .paying(paying), .change(change), .change_vld(change_vld), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_credit = 0; m_eage = 0; m_xage = 0; m_xst = 0; m_erun = 0; m_xrun = 0;
    m_eopen = 0; m_err = 0; m_ep = 0; m_xp = 0; m_eh = 0; m_xh = 0;
  endtask

  // inputs are already applied; compare outputs, advance the model, move to the next cycle
  task automatic step();
    bit ee, xe, pe, px, fm, cv, inc, dec;
    int sum;
    #1;
    ee = ep && !m_ep;
    xe = xp && !m_xp;
    pe = m_eh[1] && m_erun == DB - 1;
    px = m_xh[1] && m_xrun == DB - 1;
    fm = m_occ == CAP;
    sum = m_credit + cn;
    cv = m_xst == 1 && sum >= FEE;
    check("entry_gate", entry_gate, m_eopen);
    check("exit_gate", exit_gate, m_xst == 2);
    check("paying", paying, m_xst == 1);
    check("occupancy", occupancy, m_occ);
    check("full", full, fm);
    check("err", err, m_err);
    check("change_vld", change_vld, cv);
    check("change", change, cv ? sum - FEE : 0);
    if (rst) model_reset();
    else begin
      inc = m_eopen && ee && !fm;
      dec = m_xst == 2 && xe && m_occ > 0;
      if (xe && m_occ == 0) m_err = 1;
      if (m_eopen) begin
        if (ee || m_eage == OC - 1) begin m_eopen = 0; m_eage = 0; end
        else m_eage++;
      end else if (pe && !fm) m_eopen = 1;
      if (m_xst == 0) begin
        if (px && m_occ > 0) begin m_xst = 1; m_credit = 0; end
      end else if (m_xst == 1) begin
        if (cv) begin m_xst = 2; m_credit = 0; end
        else m_credit = sum;
      end else if (xe || m_xage == OC - 1) begin m_xst = 0; m_xage = 0; end
      else m_xage++;
      m_occ += int'(inc) - int'(dec);
      m_erun = m_eh[1] ? m_erun + 1 : 0;
      m_xrun = m_xh[1] ? m_xrun + 1 : 0;
      m_eh = {m_eh[0], eb};
      m_xh = {m_xh[0], xr};
      m_ep = ep;
      m_xp = xp;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic press_entry();
    eb = 1; repeat (6) step(); eb = 0;
  endtask

  task automatic press_exit();
    xr = 1; repeat (6) step(); xr = 0;
  endtask

  task automatic enter();
    press_entry();
    ep = 1; step(); ep = 0; step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    check("rst_occ", occupancy, 0);
    check("rst_gates", {entry_gate, exit_gate, paying, change_vld, err, full}, 0);
    // bouncy entry button, then steady high for DB cycles
    for (int i = 0; i < 10; i++) begin eb = (i % 2 == 0); step(); end
    eb = 1; repeat (4) step();
    eb = 0; repeat (2) step();
    check("bounce_gate", entry_gate, 1);
    ep = 1; step(); ep = 0; step();
    repeat (7) enter();
    check("fill_occ", occupancy, 8);
    check("fill_full", full, 1);
    press_entry();
    repeat (2) step();
    check("full_gate", entry_gate, 0);
    check("full_occ", occupancy, 8);
    rst = 1; step(); rst = 0;
    repeat (2) enter();
    check("two_occ", occupancy, 2);
    press_exit();
    check("pay_state", paying, 1);
    cn = 2; step();
    cn = 3; #1;
    check("pay_cv", change_vld, 1);
    check("pay_change", change, 2);
    step(); cn = 0;
    check("pay_gate", exit_gate, 1);
    xp = 1; step(); xp = 0; step();
    check("exit_occ", occupancy, 1);
    press_entry();
    repeat (OC - 1) step();
    check("timeout_open", entry_gate, 1);
    step();
    check("timeout_closed", entry_gate, 0);
    check("timeout_occ", occupancy, 1);
    repeat (4) enter();
    eb = 1; xr = 1; repeat (6) step(); eb = 0; xr = 0;
    cn = 3; step(); cn = 0;
    check("both_open", {entry_gate, exit_gate}, 2'b11);
    ep = 1; xp = 1; step(); ep = 0; xp = 0; step();
    check("both_occ", occupancy, 5);
    press_exit();
    cn = 2; step(); cn = 0; step();
    rst = 1; step(); rst = 0;
    check("rst_paying", paying, 0);
    check("rst_occ2", occupancy, 0);
    press_exit();
    repeat (2) step();
    check("drop_exit", paying, 0);
    xp = 1; step(); xp = 0; step();
    check("err_set", err, 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) eb = ~eb;
      if ($urandom_range(0, 7) == 0) xr = ~xr;
      ep = $urandom_range(0, 9) == 0;
      xp = $urandom_range(0, 9) == 0;
      cn = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
